spi_master_xfer_ctrl: RTL and testbench
=======================================

// Module: spi_master_xfer_ctrl
// PURPOSE
//  SPI master transaction engine; the reader/writer on the SPI side of the SPI data register bank.
//  On a send request it fetches words 0..n_tx_i from the bank, shifts the low byte of each out
//  on MOSI (SPI mode 0, MSB first), and writes the byte captured on MISO back to the same entry.
//  Drives the bank's SPI-side pointer, write enable and hold control; the host side owns the bank otherwise.
// PARAMETERS
//  N        8  bank depth (entries); AW = $clog2(N)
//  CLK_DIV  4  clk_i cycles per SCLK half-period; legal >= 2
// PORTS
//  clk_i        in   1   system clock, 10 MHz
//  rst_n_i      in   1   reset, asynchronous, active-low
//  send_i       in   1   start request, sampled in IDLE only
//  n_tx_i       in   AW  last entry index to transfer (words = n_tx_i+1), latched on start
//  rd_data_i    in   32  bank read data (registered, valid 1 cycle after addr_o)
//  miso_i       in   1   SPI serial in
//  hold_ctrl_o  out  1   1 = bank uses SPI-side pointer/write enable
//  addr_o       out  AW  SPI-side bank pointer
//  wr_en_o      out  1   SPI-side bank write enable, 1-cycle pulse
//  wr_data_o    out  32  {24'h0, rx_byte}
//  sclk_o       out  1   SPI clock, idle low
//  mosi_o       out  1   SPI serial out
//  cs_n_o       out  1   chip select, active-low
//  busy_o       out  1   1 while not IDLE
//  done_o       out  1   1-cycle pulse after final write-back
//  tx_cnt_o     out  AW  index of word currently in progress
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, cs_n_o=1, sclk_o=0, mosi_o=0, hold_ctrl_o=0, wr_en_o=0,
//    addr_o=0, wr_data_o=0, busy_o=0, done_o=0, tx_cnt_o=0, divider and bit counter 0.
//  - FSM: IDLE -> FETCH -> LOAD -> SHIFT -> WRBACK -> (FETCH | DONE) -> IDLE.
//  - IDLE: send_i=1 -> latch n_tx_i, addr_o=0, hold_ctrl_o=1, busy_o=1, go FETCH. send_i outside IDLE ignored.
//  - FETCH: 1 cycle; addr_o stable so bank registers the entry.
//  - LOAD: shift reg <= rd_data_i[7:0]; cs_n_o=0; mosi_o <= rd_data_i[7]; bit counter=0.
//  - SHIFT: divider counts CLK_DIV-1..0; at each terminal count sclk_o toggles.
//    Rising edge: sample miso_i into rx shift LSB. Falling edge: shift tx left, drive next MSB;
//    after 8th falling edge go WRBACK, sclk_o ends low. Byte time = 16*CLK_DIV cycles.
//  - WRBACK: wr_en_o=1 one cycle, wr_data_o={24'h0,rx}; addr_o unchanged.
//    If tx_cnt_o==latched n_tx -> DONE, else tx_cnt_o/addr_o +1, go FETCH.
//  - cs_n_o held low across all words of one transaction (no de-assert between bytes).
//  - DONE: cs_n_o=1, hold_ctrl_o=0, done_o=1 for 1 cycle, busy_o=0 next cycle, IDLE.
//  - n_tx_i=0: single word. n_tx_i=N-1: all entries; pointer never wraps past n_tx.
//  - Bank bits [31:8] of transferred entries are overwritten with 0 by write-back.
//  - hold_ctrl_o high continuously from FETCH of word 0 through WRBACK of last word.
//  - Reset mid-transfer: cs_n_o rises and sclk_o falls immediately; partial byte not written.
// CONFIGURATION
//  SPI_LOOPBACK_EN defined: rx shift samples internal mosi_o instead of miso_i (self-test);
//    miso_i ignored, each entry is written back with its own low byte.
//  Undefined: rx shift samples miso_i; no loopback path exists.
// TESTING
//  T1 reset: rst_n_i=0 mid-SHIFT -> cs_n_o=1, sclk_o=0, busy_o=0 same cycle; no wr_en_o pulse.
//  T2 single word: entry0=32'hDEADBEA5, n_tx_i=0, miso slave returns 8'h3C -> MOSI 1010_0101,
//     entry0=32'h0000003C, done_o one pulse, 8 SCLK rising edges, CLK_DIV=4 -> 64 cycles SHIFT.
//  T3 burst: n_tx_i=N-1, entries 0..7=8'h10..8'h17, slave echoes ~byte -> entries=8'hEF..8'hE8,
//     cs_n_o low continuously, exactly 8 wr_en_o pulses at addr 0..7.
//  T4 send_i pulsed during busy_o=1 -> ignored; no extra words, single done_o.
//  T5 SPI_LOOPBACK_EN: entries 0..3=8'hA5,8'h5A,8'hFF,8'h00, n_tx_i=3 -> low bytes unchanged,
//     bits[31:8] cleared.
//  T6 mode-0 check: MOSI stable across every sclk_o rising edge; sclk_o low when cs_n_o toggles.

Source files
------------

// File: rtl/spi_master_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_xfer_ctrl
//   SPI master transaction engine sitting on the SPI side of a data register
//   bank. A send request walks entries 0..n_tx_i. For each entry it fetches the
//   word, shifts the low byte out on MOSI (mode 0, MSB first) and writes the
//   byte captured on MISO back to the same entry as {24'h0, rx_byte}.
//   While a transaction runs, hold_ctrl_o hands the bank pointer and write
//   enable to this block.
//
//   Build option: define SPI_LOOPBACK_EN to feed the receive shifter from the
//   internal MOSI line instead of miso_i. Each entry is then written back with
//   its own low byte, which serves as a self-test.
// -----------------------------------------------------------------------------
module spi_master_xfer_ctrl #(
  parameter int N       = 8,
  parameter int CLK_DIV = 4,
  localparam int AW     = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          send_i,
  input  logic [AW-1:0] n_tx_i,
  input  logic [31:0]   rd_data_i,
  input  logic          miso_i,
  output logic          hold_ctrl_o,
  output logic [AW-1:0] addr_o,
  output logic          wr_en_o,
  output logic [31:0]   wr_data_o,
  output logic          sclk_o,
  output logic          mosi_o,
  output logic          cs_n_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] tx_cnt_o
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    SHIFT  = 3'd3,
    WRBACK = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t        state;
  logic [AW-1:0] n_last;    // last entry index, latched at start
  logic [DW-1:0] div_cnt;   // SCLK half-period divider
  logic [2:0]    bit_cnt;   // falling edges seen in the current byte
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          rx_bit;    // serial input seen by the receive shifter

  // Only the low byte of a bank word is shifted out.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_data_i[31:8];

`ifdef SPI_LOOPBACK_EN
  // Self-test: the receive shifter listens to our own MOSI line.
  logic unused_miso;
  assign unused_miso = miso_i;
  assign rx_bit      = mosi_o;
`else
  assign rx_bit = miso_i;
`endif

  // Transaction FSM with registered outputs, SCLK generation and the shifters.
  // NOTE: all state here updates with non-blocking assignments so every register
  // samples the values from before the edge; blocking assignments would make the
  // shift/toggle ordering depend on statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      n_last      <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      hold_ctrl_o <= 1'b0;
      addr_o      <= '0;
      wr_en_o     <= 1'b0;
      wr_data_o   <= '0;
      sclk_o      <= 1'b0;
      mosi_o      <= 1'b0;
      cs_n_o      <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      tx_cnt_o    <= '0;
    end else begin
      // Single-cycle strobes default low.
      wr_en_o <= 1'b0;
      done_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (send_i) begin
            n_last      <= n_tx_i;
            addr_o      <= '0;
            tx_cnt_o    <= '0;
            hold_ctrl_o <= 1'b1;
            busy_o      <= 1'b1;
            state       <= FETCH;
          end
        end

        // The pointer is stable for one cycle so the bank can register the entry.
        FETCH: state <= LOAD;

        LOAD: begin
          tx_sr   <= rd_data_i[7:0];
          rx_sr   <= '0;
          mosi_o  <= rd_data_i[7];
          cs_n_o  <= 1'b0;
          bit_cnt <= '0;
          div_cnt <= DIV_MAX;
          state   <= SHIFT;
        end

        SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt <= DIV_MAX;
            sclk_o  <= ~sclk_o;
            if (!sclk_o) begin
              // Rising edge: capture the slave's bit.
              rx_sr <= {rx_sr[6:0], rx_bit};
            end else begin
              // Falling edge: present the next MSB. The 8th edge ends the byte.
              tx_sr  <= {tx_sr[6:0], 1'b0};
              mosi_o <= tx_sr[6];
              if (bit_cnt == 3'd7) begin
                wr_en_o   <= 1'b1;
                wr_data_o <= {24'h0, rx_sr};
                state     <= WRBACK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt - DW'(1);
          end
        end

        // The write pulse is active in this cycle; choose the next word or finish.
        WRBACK: begin
          if (tx_cnt_o == n_last) begin
            cs_n_o      <= 1'b1;
            hold_ctrl_o <= 1'b0;
            done_o      <= 1'b1;
            state       <= DONE;
          end else begin
            tx_cnt_o <= tx_cnt_o + AW'(1);
            addr_o   <= addr_o + AW'(1);
            state    <= FETCH;
          end
        end

        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_xfer_ctrl
//   Randomized bench for spi_master_xfer_ctrl. It models:
//     - the register bank, with registered reads and a host-side write port;
//     - a mode-0 SPI slave that returns a chosen byte per word and records
//       every byte it receives.
//   Expected values come from transaction-level rules:
//     - each entry 0..n ends up holding {24'h0, reply}, or its own low byte
//       under SPI_LOOPBACK_EN;
//     - the slave sees each original low byte;
//     - each word costs 3 + 16*CLK_DIV busy cycles, with one extra cycle for
//       the done cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_xfer_ctrl;

  localparam int N        = 8;
  localparam int CLK_DIV  = 4;
  localparam int AW       = $clog2(N);
  localparam int WORD_CYC = 3 + 16 * CLK_DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          send;
  logic [AW-1:0] n_tx;
  logic [31:0]   rd_data;
  logic          miso_i = 1'b0;
  logic          hold_ctrl_o, wr_en_o, sclk_o, mosi_o, cs_n_o, busy_o, done_o;
  logic [AW-1:0] addr_o, tx_cnt_o;
  logic [31:0]   wr_data_o;

  spi_master_xfer_ctrl #(.N(N), .CLK_DIV(CLK_DIV)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .send_i      (send),
    .n_tx_i      (n_tx),
    .rd_data_i   (rd_data),
    .miso_i      (miso_i),
    .hold_ctrl_o (hold_ctrl_o),
    .addr_o      (addr_o),
    .wr_en_o     (wr_en_o),
    .wr_data_o   (wr_data_o),
    .sclk_o      (sclk_o),
    .mosi_o      (mosi_o),
    .cs_n_o      (cs_n_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .tx_cnt_o    (tx_cnt_o)
  );

  always #50 clk = ~clk;   // 10 MHz

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- bank model ----------------
  logic [31:0]   bank [N];
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [31:0]   host_data = '0;

  always @(posedge clk) begin
    rd_data <= bank[addr_o];
    if (hold_ctrl_o) begin
      if (wr_en_o) bank[addr_o] <= wr_data_o;
    end else if (host_we) begin
      bank[host_addr] <= host_data;
    end
  end

  // ---------------- slave model and monitors ----------------
  logic [7:0] resp [N];        // slave reply byte per word
  logic [7:0] cap_q[$];        // bytes the slave received
  int         wr_addr_q[$];
  int wr_cnt = 0, done_cnt = 0, busy_cyc = 0, rise_cnt = 0, cs_fall_cnt = 0;
  int mode_err = 0, tx_err = 0;
  int sl_cnt = 0, sl_idx = 0;
  logic [7:0] sl_tx = '0, sl_rx = '0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy_o) busy_cyc++;
      if (done_o) done_cnt++;
      if (wr_en_o) begin
        wr_cnt++;
        wr_addr_q.push_back(int'(addr_o));
        if (tx_cnt_o != addr_o || !hold_ctrl_o) tx_err++;
      end
      if (cs_n_o !== prev_cs && (sclk_o || prev_sclk)) mode_err++;
      if (!cs_n_o && prev_cs) begin
        cs_fall_cnt++;
        sl_cnt = 0;
        sl_idx = 0;
        sl_tx  = resp[0];
        miso_i = sl_tx[7];
      end
      if (sclk_o && !prev_sclk) begin
        rise_cnt++;
        if (mosi_o !== prev_mosi) mode_err++;
        sl_rx = {sl_rx[6:0], mosi_o};
        sl_cnt++;
      end
      if (!sclk_o && prev_sclk) begin
        if (sl_cnt == 8) begin
          cap_q.push_back(sl_rx);
          sl_cnt = 0;
          sl_idx++;
          sl_tx  = (sl_idx < N) ? resp[sl_idx] : 8'h00;
          miso_i = sl_tx[7];
        end else begin
          miso_i = sl_tx[7 - sl_cnt];
        end
      end
    end
    prev_cs   = cs_n_o;
    prev_sclk = sclk_o;
    prev_mosi = mosi_o;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    host_addr = AW'(a);
    host_data = d;
    host_we   = 1'b1;
    step();
    host_we   = 1'b0;
  endtask

  task automatic randomize_bank_resp();
    for (int i = 0; i < N; i++) begin
      host_write(i, $urandom);
      resp[i] = 8'($urandom);
    end
  endtask

  // Run one transaction covering entries 0..n and check it against the reference rules.
  task automatic run_xfer(input int n, input bit poke_send);
    logic [31:0] orig [N];
    logic [31:0] exp_word;
    int b_wr, b_cap, b_done, b_busy, b_rise, b_fall, b_mode, b_tx, t;
    for (int i = 0; i < N; i++) orig[i] = bank[i];
    b_wr = wr_cnt; b_cap = cap_q.size(); b_done = done_cnt; b_busy = busy_cyc;
    b_rise = rise_cnt; b_fall = cs_fall_cnt; b_mode = mode_err; b_tx = tx_err;

    n_tx = AW'(n);
    send = 1'b1;
    step();
    send = 1'b0;
    n_tx = AW'($urandom);
    if (poke_send) begin
      repeat (30) step();
      send = 1'b1; step(); send = 1'b0;
      repeat (70) step();
      send = 1'b1; repeat (3) step(); send = 1'b0;
    end
    t = 0;
    while (done_cnt == b_done && t < 20000) begin
      step();
      t++;
    end
    check("done_timeout", 32'(t < 20000), 32'd1);
    repeat (4) step();

    check("done_pulses", 32'(done_cnt - b_done), 32'd1);
    check("wr_pulses", 32'(wr_cnt - b_wr), 32'(n + 1));
    check("busy_cycles", 32'(busy_cyc - b_busy), 32'((n + 1) * WORD_CYC + 1));
    check("sclk_rises", 32'(rise_cnt - b_rise), 32'(8 * (n + 1)));
    check("cs_falls", 32'(cs_fall_cnt - b_fall), 32'd1);
    check("mode0_errs", 32'(mode_err - b_mode), 32'd0);
    check("txcnt_errs", 32'(tx_err - b_tx), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);
    check("idle_cs_n", 32'(cs_n_o), 32'd1);
    check("idle_hold", 32'(hold_ctrl_o), 32'd0);
    if (wr_addr_q.size() >= b_wr + n + 1)
      for (int i = 0; i <= n; i++)
        check($sformatf("wr_addr[%0d]", i), 32'(wr_addr_q[b_wr + i]), 32'(i));
    if (cap_q.size() >= b_cap + n + 1)
      for (int i = 0; i <= n; i++)
        check($sformatf("mosi_byte[%0d]", i), 32'(cap_q[b_cap + i]), 32'(orig[i][7:0]));
    else
      check("mosi_bytes", 32'(cap_q.size() - b_cap), 32'(n + 1));
    for (int i = 0; i < N; i++) begin
`ifdef SPI_LOOPBACK_EN
      exp_word = (i <= n) ? {24'h0, orig[i][7:0]} : orig[i];
`else
      exp_word = (i <= n) ? {24'h0, resp[i]} : orig[i];
`endif
      check($sformatf("entry[%0d]", i), bank[i], exp_word);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int b_wr, b_rise, t;
    logic [31:0] e0;
    rst_n = 1'b0;
    send  = 1'b0;
    n_tx  = '0;
    repeat (3) step();
    check("rst_cs_n", 32'(cs_n_o), 32'd1);
    check("rst_sclk", 32'(sclk_o), 32'd0);
    check("rst_mosi", 32'(mosi_o), 32'd0);
    check("rst_busy_done", {30'd0, busy_o, done_o}, 32'd0);
    check("rst_hold_wr", {30'd0, hold_ctrl_o, wr_en_o}, 32'd0);
    check("rst_addr_txcnt", {26'd0, addr_o, tx_cnt_o}, 32'd0);
    check("rst_wr_data", wr_data_o, 32'd0);
    rst_n = 1'b1;
    step();

    // Single word
    randomize_bank_resp();
    host_write(0, 32'hDEADBEA5);
    resp[0] = 8'h3C;
    run_xfer(0, 1'b0);

    // Full burst: the slave returns the inverse of each entry's byte
    for (int i = 0; i < N; i++) begin
      host_write(i, 32'hCAFE0010 + 32'(i));
      resp[i] = ~(8'h10 + 8'(i));
    end
    run_xfer(N - 1, 1'b0);

    // send_i pulsed while busy is ignored
    randomize_bank_resp();
    run_xfer(3, 1'b1);

    // Self-test pattern (low bytes preserved under SPI_LOOPBACK_EN)
    randomize_bank_resp();
    host_write(0, 32'h123456A5);
    host_write(1, 32'h9ABCDE5A);
    host_write(2, 32'h000000FF);
    host_write(3, 32'hFFFFFF00);
    run_xfer(3, 1'b0);

    // Random transactions
    for (int k = 0; k < 6; k++) begin
      randomize_bank_resp();
      run_xfer($urandom_range(0, N - 1), 1'b0);
    end

    // Reset mid-transfer
    randomize_bank_resp();
    e0     = bank[0];
    b_wr   = wr_cnt;
    b_rise = rise_cnt;
    n_tx   = AW'(2);
    send   = 1'b1;
    step();
    send   = 1'b0;
    t = 0;
    while (rise_cnt < b_rise + 3 && t < 2000) begin
      step();
      t++;
    end
    check("rst_mid_reach", 32'(t < 2000), 32'd1);
    #10;
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs_n", 32'(cs_n_o), 32'd1);
    check("rst_mid_sclk", 32'(sclk_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_hold", 32'(hold_ctrl_o), 32'd0);
    repeat (2) step();
    check("rst_mid_no_wr", 32'(wr_cnt - b_wr), 32'd0);
    check("rst_mid_entry0", bank[0], e0);
    rst_n = 1'b1;
    step();

    // Recovery after reset
    randomize_bank_resp();
    run_xfer(1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
